// File: rtl/ex_8_2_run_ctrl_if.sv
// Link between the run controller and the ex_8_2_asmd pair it launches.
interface ex_8_2_run_ctrl_if;
  logic       start;
  logic [3:0] A;
  logic       E;
  logic       F;

  modport master (output start, input A, E, F);
  modport slave  (input start, output A, E, F);
endinterface

// File: rtl/ex_8_2_run_ctrl.sv
// Run controller: synchronizes/debounces a raw request, launches the ASMD,
// waits for F with a timeout, captures the result and tracks run/miss/timeout status.
module ex_8_2_run_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int TIMEOUT     = 32,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  req,
  ex_8_2_run_ctrl_if.master     asmd,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            result_A,
  output logic                  result_E,
  output logic [CNT_W-1:0]      run_count,
  output logic                  timeout,
  output logic                  miss
);

  localparam int TW = (TIMEOUT  > 1) ? $clog2(TIMEOUT)  : 1;
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_CLR, S_RUN, S_DONE, S_ERR
  } state_e;

  // ---------------- request conditioning ----------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DW-1:0]          db_cnt_q, db_cnt_d;
  logic                   req_db_q, req_db_d;
  logic                   req_db_prev_q;
  logic                   req_s;
  logic                   launch;

  assign req_s = sync_q[SYNC_STAGES-1];

  // The level only moves after DEBOUNCE consecutive disagreeing samples;
  // any agreeing sample restarts the count.
  always_comb begin
    db_cnt_d = '0;
    req_db_d = req_db_q;
    if (req_s != req_db_q) begin
      if (db_cnt_q == DW'(DEBOUNCE - 1)) req_db_d = req_s;
      else                               db_cnt_d = db_cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync_q        <= '0;
      db_cnt_q      <= '0;
      req_db_q      <= 1'b0;
      req_db_prev_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], req};
      db_cnt_q      <= db_cnt_d;
      req_db_q      <= req_db_d;
      req_db_prev_q <= req_db_q;
    end
  end

  assign launch = req_db_q & ~req_db_prev_q;

  // ---------------- run FSM ----------------
  state_e             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [3:0]         res_a_q, res_a_d;
  logic               res_e_q, res_e_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic               miss_q, miss_d;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      res_a_q   <= '0;
      res_e_q   <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      res_a_q   <= res_a_d;
      res_e_q   <= res_e_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      miss_q    <= miss_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    res_a_d   = res_a_q;
    res_e_d   = res_e_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    miss_d    = miss_q | (launch & (state_q != S_IDLE));
    case (state_q)
      S_IDLE: if (launch) begin
        state_d   = S_ARM;
        timeout_d = 1'b0;
      end
      S_ARM:  state_d = S_CLR;
      // F may still be high from the previous run here; it is deliberately ignored.
      S_CLR: begin
        state_d = S_RUN;
        timer_d = '0;
      end
      S_RUN: begin
        if (asmd.F) begin
          state_d = S_DONE;
          res_a_d = asmd.A;
          res_e_d = asmd.E;
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERR: begin
        state_d   = S_IDLE;
        timeout_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign asmd.start = (state_q == S_ARM);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign result_A   = res_a_q;
  assign result_E   = res_e_q;
  assign run_count  = cnt_q;
  assign timeout    = timeout_q;
  assign miss       = miss_q;

endmodule

// File: tb/tb_ex_8_2_run_ctrl.sv
// Directed bench for ex_8_2_run_ctrl; the bench plays the ASMD stub on the interface.
module tb_ex_8_2_run_ctrl;
  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       req = 1'b0;
  logic       busy, done, result_E, timeout, miss;
  logic [3:0] result_A;
  logic [7:0] run_count;

  int tests_run = 0;
  int fails     = 0;
  int start_cnt = 0;
  int done_cnt  = 0;

  ex_8_2_run_ctrl_if asmd_if ();

  ex_8_2_run_ctrl #(.SYNC_STAGES(2), .DEBOUNCE(4), .TIMEOUT(32), .CNT_W(8)) dut (
    .clk(clk), .rstb(rstb), .req(req), .asmd(asmd_if),
    .busy(busy), .done(done), .result_A(result_A), .result_E(result_E),
    .run_count(run_count), .timeout(timeout), .miss(miss)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (asmd_if.start === 1'b1) start_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (asmd_if.start !== 1'b1 && n < 100) begin tick(); n++; end
    tests_run++;
    if (asmd_if.start !== 1'b1) begin
      fails++; $display("FAIL wait_start: start never seen within %0d cycles", n);
    end
  endtask

  task automatic release_req;
    req = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_reset;
    asmd_if.A = 4'd0; asmd_if.E = 1'b0; asmd_if.F = 1'b0;
    rstb = 1'b0; req = 1'b0;
    repeat (3) tick();
    tests_run++;
    if ({asmd_if.start, busy, done, result_A, result_E, run_count, timeout, miss} !== 17'd0) begin
      fails++; $display("FAIL reset_outputs: got %b required all zero",
        {asmd_if.start, busy, done, result_A, result_E, run_count, timeout, miss});
    end
    rstb = 1'b1;
    repeat (3) tick();
    tests_run++;
    if ({asmd_if.start, busy, done} !== 3'b000) begin
      fails++; $display("FAIL post_reset_idle: start/busy/done=%b required 000", {asmd_if.start, busy, done});
    end
  endtask

  task automatic test_basic;
    int n, s0, d0;
    s0 = start_cnt; d0 = done_cnt;
    req = 1'b1;
    wait_start(n);
    tests_run++;
    if (n != 7) begin fails++; $display("FAIL launch_latency: got %0d required 7", n); end
    repeat (6) tick();
    asmd_if.A = 4'b1101; asmd_if.E = 1'b1; asmd_if.F = 1'b1;
    tick();
    asmd_if.F = 1'b0; asmd_if.A = 4'd0; asmd_if.E = 1'b0;
    tests_run++;
    if (done !== 1'b1) begin fails++; $display("FAIL basic_done: got %b required 1", done); end
    tests_run++;
    if (result_A !== 4'b1101 || result_E !== 1'b1) begin
      fails++; $display("FAIL basic_result: got A=%b E=%b required A=1101 E=1", result_A, result_E);
    end
    tests_run++;
    if (run_count !== 8'd1) begin fails++; $display("FAIL basic_count: got %0d required 1", run_count); end
    tick();
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL basic_idle: busy=%b done=%b required 0 0", busy, done);
    end
    tests_run++;
    if (start_cnt - s0 != 1 || done_cnt - d0 != 1) begin
      fails++; $display("FAIL basic_pulses: starts=%0d dones=%0d required 1 1", start_cnt - s0, done_cnt - d0);
    end
    release_req();
  endtask

  task automatic test_bounce;
    int n, s0;
    s0 = start_cnt;
    for (int i = 0; i < 10; i++) begin
      req = (i % 2 == 0);
      tick();
    end
    repeat (3) tick();
    tests_run++;
    if (start_cnt != s0) begin fails++; $display("FAIL bounce_no_start: starts=%0d required 0", start_cnt - s0); end
    req = 1'b1;
    wait_start(n);
    tests_run++;
    if (n != 7) begin fails++; $display("FAIL bounce_latency: got %0d required 7", n); end
    repeat (2) tick();
    asmd_if.F = 1'b1;
    tick();
    asmd_if.F = 1'b0;
    tests_run++;
    if (done !== 1'b1) begin fails++; $display("FAIL bounce_done: got %b required 1", done); end
    repeat (3) tick();
    tests_run++;
    if (start_cnt - s0 != 1) begin fails++; $display("FAIL bounce_one_start: got %0d required 1", start_cnt - s0); end
    release_req();
  endtask

  task automatic test_timeout;
    int n, d0;
    logic [7:0] rc0;
    d0 = done_cnt; rc0 = run_count;
    req = 1'b1;
    wait_start(n);
    repeat (34) tick();
    tests_run++;
    if (busy !== 1'b1 || timeout !== 1'b0) begin
      fails++; $display("FAIL timeout_err_cycle: busy=%b timeout=%b required 1 0", busy, timeout);
    end
    tick();
    tests_run++;
    if (timeout !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL timeout_flag: timeout=%b busy=%b required 1 0", timeout, busy);
    end
    tests_run++;
    if (done_cnt != d0 || run_count !== rc0) begin
      fails++; $display("FAIL timeout_no_done: dones=%0d count=%0d required 0 %0d", done_cnt - d0, run_count, rc0);
    end
    release_req();
  endtask

  task automatic test_boundary;
    int n;
    tests_run++;
    if (timeout !== 1'b1) begin fails++; $display("FAIL boundary_pre_timeout: got %b required 1", timeout); end
    req = 1'b1;
    wait_start(n);
    tests_run++;
    if (timeout !== 1'b0) begin fails++; $display("FAIL timeout_clear_on_launch: got %b required 0", timeout); end
    repeat (33) tick();
    asmd_if.F = 1'b1; asmd_if.A = 4'b0110; asmd_if.E = 1'b0;
    tick();
    asmd_if.F = 1'b0;
    tests_run++;
    if (done !== 1'b1 || timeout !== 1'b0) begin
      fails++; $display("FAIL boundary_done: done=%b timeout=%b required 1 0", done, timeout);
    end
    tests_run++;
    if (result_A !== 4'b0110 || result_E !== 1'b0) begin
      fails++; $display("FAIL boundary_result: A=%b E=%b required 0110 0", result_A, result_E);
    end
    tick();
    tests_run++;
    if (timeout !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL boundary_after: timeout=%b busy=%b required 0 0", timeout, busy);
    end
    release_req();
  endtask

  task automatic test_miss;
    int n, s0;
    logic [7:0] rc0;
    tests_run++;
    if (miss !== 1'b0) begin fails++; $display("FAIL miss_pre: got %b required 0", miss); end
    s0 = start_cnt; rc0 = run_count;
    req = 1'b1;
    wait_start(n);
    repeat (2) tick();
    req = 1'b0;
    repeat (8) tick();
    req = 1'b1;
    repeat (10) tick();
    tests_run++;
    if (miss !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL miss_flag: miss=%b busy=%b required 1 1", miss, busy);
    end
    asmd_if.F = 1'b1; asmd_if.A = 4'b0011; asmd_if.E = 1'b1;
    tick();
    asmd_if.F = 1'b0;
    tests_run++;
    if (done !== 1'b1 || run_count !== 8'(rc0 + 8'd1) || result_A !== 4'b0011) begin
      fails++; $display("FAIL miss_run_done: done=%b count=%0d A=%b required 1 %0d 0011",
        done, run_count, result_A, 8'(rc0 + 8'd1));
    end
    repeat (3) tick();
    tests_run++;
    if (start_cnt - s0 != 1 || miss !== 1'b1) begin
      fails++; $display("FAIL miss_no_restart: starts=%0d miss=%b required 1 1", start_cnt - s0, miss);
    end
    release_req();
  endtask

  task automatic test_reset_mid_run;
    int n, d0;
    req = 1'b1;
    wait_start(n);
    repeat (3) tick();
    tests_run++;
    if (busy !== 1'b1) begin fails++; $display("FAIL midrun_busy: got %b required 1", busy); end
    rstb = 1'b0;
    #1;
    tests_run++;
    if ({asmd_if.start, busy, done, result_A, result_E, run_count, timeout, miss} !== 17'd0) begin
      fails++; $display("FAIL midrun_reset_outputs: got %b required all zero",
        {asmd_if.start, busy, done, result_A, result_E, run_count, timeout, miss});
    end
    req = 1'b0;
    tick();
    rstb = 1'b1;
    d0 = done_cnt;
    repeat (40) tick();
    tests_run++;
    if (done_cnt != d0 || busy !== 1'b0 || run_count !== 8'd0) begin
      fails++; $display("FAIL midrun_no_done: dones=%0d busy=%b count=%0d required 0 0 0",
        done_cnt - d0, busy, run_count);
    end
  endtask

  task automatic test_wrap;
    int n;
    for (int i = 0; i < 256; i++) begin
      req = 1'b1;
      wait_start(n);
      repeat (2) tick();
      asmd_if.F = 1'b1;
      tick();
      asmd_if.F = 1'b0;
      tests_run++;
      if ({done, run_count} !== {1'b1, 8'(i + 1)}) begin
        fails++; $display("FAIL wrap_run%0d: done=%b count=%0d required 1 %0d", i, done, run_count, (i + 1) % 256);
      end
      req = 1'b0;
      repeat (8) tick();
    end
    tests_run++;
    if (run_count !== 8'd0) begin fails++; $display("FAIL wrap_final: got %0d required 0", run_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounce();
    test_timeout();
    test_boundary();
    test_miss();
    test_reset_mid_run();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/ex_8_2_run_ctrl.md
# ex_8_2_run_ctrl

Upstream run controller for the `ex_8_2_asmd` datapath/controller pair. It takes a raw operator request line, synchronizes and debounces it, and issues a single-cycle `start` to the ASMD. It then waits for the ASMD to finish (`F` rising), captures the final `A`/`E` result, counts completed runs, and flags timeouts and dropped requests.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth for `req` (minimum 2).
- `DEBOUNCE`, 4: number of consecutive stable synchronized samples required to change the debounced level (minimum 1).
- `TIMEOUT`, 32: maximum number of RUN-state cycles to wait for `F`.
- `CNT_W`, 8: width of the run counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock; all flops on the rising edge.
- `rstb` in 1: asynchronous active-low reset.
- `req` in 1: raw asynchronous request level.
- `A` in 4: ASMD counter value.
- `E` in 1: ASMD E flag.
- `F` in 1: ASMD F flag (run complete).
- `start` out 1: start pulse to the ASMD.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse on run completion.
- `result_A` out 4: `A` captured at completion.
- `result_E` out 1: `E` captured at completion.
- `run_count` out CNT_W: completed-run count.
- `timeout` out 1: sticky; last run timed out.
- `miss` out 1: sticky; a launch arrived while busy.

## Operation
- **Sync:** `req` passes through a SYNC_STAGES flop chain to give `req_s`.
- **Debounce:** `req_db` takes the value of `req_s` only after `req_s` differs from `req_db` for DEBOUNCE consecutive cycles. Any disagreement-free cycle reloads the stability counter.
- **Launch:** a one-cycle internal pulse on each 0→1 transition of `req_db`.
- **FSM states:** IDLE, ARM, CLR, RUN, DONE, ERR.
  - IDLE: launch → ARM, and clear `timeout`.
  - ARM: `start`=1 for exactly this cycle → CLR.
  - CLR: one cycle, allowing the ASMD to clear A/F → RUN; the timer is loaded with 0.
  - RUN: `F`=1 → DONE, capturing `result_A`<=`A` and `result_E`<=`E` on that edge. Otherwise, if timer = TIMEOUT-1 → ERR; else the timer increments.
  - DONE: `done`=1 and `run_count`+1 (wraps modulo 2^CNT_W) → IDLE.
  - ERR: set `timeout` → IDLE. `result_*` and `run_count` are unchanged.
- A launch in any state other than IDLE is ignored and sets `miss`. `miss` clears only on reset.
- A launch in ERR is also dropped and sets `miss`.
- `F` is ignored in every state except RUN. If `F` is still high in CLR, it is not treated as completion.

## Timing
- Reset values: state=IDLE, `start`=0, `busy`=0, `done`=0, `result_A`=0, `result_E`=0, `run_count`=0, `timeout`=0, `miss`=0, sync chain=0, `req_db`=0, counters=0.
- Reset is asynchronous and may be asserted mid-run. Outputs go to their reset values immediately; no `done` or count is produced for the aborted run.
- Latency from `req` rising to `req_db` rising is SYNC_STAGES+DEBOUNCE cycles (±1 for the asynchronous sampling edge).
- `start` is asserted in the cycle after the launch pulse.
- For completion: if `F` is first sampled high n cycles after RUN entry (n=0..TIMEOUT-1), then `done` is high in cycle start+2+n+1 relative to the `start` cycle.
- Timeout: with `F` never high, the FSM makes exactly TIMEOUT RUN cycles, then one ERR cycle; `timeout` is visible the cycle after ERR.
- If `F` rises in the same cycle the timer reaches TIMEOUT-1, `F` wins: DONE, no timeout.
- `busy` rises together with `start` and falls the cycle after `done` or ERR.

## Test plan
- **Basic run:** `req` 0→1 held high; the stub drives `F`=1 with `A`=4'b1101, `E`=1 on the 5th RUN cycle. Required: exactly one `start` pulse, `done` pulse, `result_A`=4'b1101, `result_E`=1, `run_count`=1, `busy` deasserted afterwards.
- **Bounce rejection:** `req` toggles every cycle for 10 cycles, then stays high. Required: exactly one `start`, produced only after DEBOUNCE stable cycles.
- **Timeout:** `F` is held at 0. Required: `start`, then after 32 RUN cycles `timeout`=1, no `done`, `run_count` unchanged. A subsequent launch clears `timeout`.
- **Boundary:** `F` rises exactly on RUN cycle 31 (timer=31). Required: `done`=1, `timeout`=0.
- **Miss:** a second debounced `req` rise occurs during RUN. Required: no second `start`, `miss`=1, and the first run completes normally.
- **Reset mid-run and wrap:** `rstb` pulses low during RUN; all outputs go to 0 immediately. Separately, 256 runs with CNT_W=8 give `run_count`=0 with the 256th `done`.
